// File: rtl/cell_sweep_seq.sv
// cell_sweep_seq: self-test sequencer for the cell mux. It sweeps every page and every
// input vector, waits a settle time, folds each sampled cell output into a rotate-XOR
// signature, and reports one signature per page. In manual mode it forwards host-chosen
// controls instead. Every output comes straight from a register.
module cell_sweep_seq #(
    parameter int PAGE_W    = 5,
    parameter int IN_W      = 6,
    parameter int OUT_W     = 8,
    parameter int SIG_W     = 16,
    parameter int NUM_PAGES = 32,
    parameter int SETTLE    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode_manual,
    input  logic [PAGE_W-1:0] man_page,
    input  logic [IN_W-1:0]   man_in,
    input  logic              man_gate,
    input  logic [OUT_W-1:0]  cell_out,
    output logic [PAGE_W-1:0] page_o,
    output logic [IN_W-1:0]   in_o,
    output logic              gate_o,
    output logic              busy,
    output logic              sig_valid,
    output logic [PAGE_W-1:0] sig_page,
    output logic [SIG_W-1:0]  signature,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // The wait counter only ever holds values up to SETTLE-1.
    localparam int                WC_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WC_W-1:0]   WC_LOAD   = WC_W'(SETTLE - 1);
    // The vector counter is one bit wider than the input bus, so the last vector never wraps.
    localparam logic [IN_W:0]     VEC_LAST  = (IN_W + 1)'((1 << IN_W) - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

    // Rotate the accumulator left by one bit, then XOR in the zero-extended sample.
    function automatic logic [SIG_W-1:0] fold_sample(input logic [SIG_W-1:0] acc,
                                                     input logic [OUT_W-1:0] sample);
        fold_sample = {acc[SIG_W-2:0], acc[SIG_W-1]} ^ SIG_W'(sample);
    endfunction

    state_t              r_state,     w_state;
    logic [PAGE_W-1:0]   r_page,      w_page;
    logic [IN_W:0]       r_vec,       w_vec;
    logic [SIG_W-1:0]    r_acc,       w_acc;
    logic [WC_W-1:0]     r_wcnt,      w_wcnt;
    logic [PAGE_W-1:0]   r_page_o,    w_page_o;
    logic [IN_W-1:0]     r_in_o,      w_in_o;
    logic                r_gate_o,    w_gate_o;
    logic                r_busy,      w_busy;
    logic                r_sig_valid, w_sig_valid;
    logic [PAGE_W-1:0]   r_sig_page,  w_sig_page;
    logic [SIG_W-1:0]    r_signature, w_signature;
    logic                r_done_pend, w_done_pend;
    logic                r_done,      w_done;
    logic [SIG_W-1:0]    w_fold;

    assign w_fold    = fold_sample(r_acc, cell_out);

    assign page_o    = r_page_o;
    assign in_o      = r_in_o;
    assign gate_o    = r_gate_o;
    assign busy      = r_busy;
    assign sig_valid = r_sig_valid;
    assign sig_page  = r_sig_page;
    assign signature = r_signature;
    assign done      = r_done;

    // Next-state logic: sweep sequencing, manual forwarding, abort handling and pulses.
    always_comb begin
        w_state     = r_state;
        w_page      = r_page;
        w_vec       = r_vec;
        w_acc       = r_acc;
        w_wcnt      = r_wcnt;
        w_page_o    = r_page_o;
        w_in_o      = r_in_o;
        w_gate_o    = r_gate_o;
        w_sig_valid = 1'b0;
        w_sig_page  = r_sig_page;
        w_signature = r_signature;
        w_done_pend = 1'b0;
        // done lags the final signature pulse by one cycle.
        w_done      = r_done_pend;

        if ((r_state != S_IDLE) && abort) begin
            // An abandoned sweep reports nothing and leaves the mux controls parked at zero.
            w_state  = S_IDLE;
            w_page   = {PAGE_W{1'b0}};
            w_vec    = {(IN_W + 1){1'b0}};
            w_acc    = {SIG_W{1'b0}};
            w_page_o = {PAGE_W{1'b0}};
            w_in_o   = {IN_W{1'b0}};
            w_gate_o = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mode_manual) begin
                        w_page_o = man_page;
                        w_in_o   = man_in;
                        w_gate_o = man_gate;
                    end else if (start && !abort) begin
                        w_page  = {PAGE_W{1'b0}};
                        w_vec   = {(IN_W + 1){1'b0}};
                        w_acc   = {SIG_W{1'b0}};
                        w_state = S_APPLY;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
                S_APPLY: begin
                    w_page_o = r_page;
                    w_in_o   = r_vec[IN_W-1:0];
                    w_gate_o = 1'b1;
                    w_wcnt   = WC_LOAD;
                    w_state  = S_WAIT;
                end
                S_WAIT: begin
                    if (r_wcnt == {WC_W{1'b0}}) begin
                        w_state = S_CAPTURE;
                    end else begin
                        w_wcnt = r_wcnt - WC_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (r_vec != VEC_LAST) begin
                        w_acc   = w_fold;
                        w_vec   = r_vec + (IN_W + 1)'(1);
                        w_state = S_APPLY;
                    end else begin
                        w_signature = w_fold;
                        w_sig_page  = r_page;
                        w_sig_valid = 1'b1;
                        w_acc       = {SIG_W{1'b0}};
                        w_vec       = {(IN_W + 1){1'b0}};
                        if (r_page == PAGE_LAST) begin
                            w_done_pend = 1'b1;
                            w_gate_o    = 1'b0;
                            w_state     = S_IDLE;
                        end else begin
                            w_page  = r_page + PAGE_W'(1);
                            w_state = S_APPLY;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end

        w_busy = (w_state != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_page      <= {PAGE_W{1'b0}};
            r_vec       <= {(IN_W + 1){1'b0}};
            r_acc       <= {SIG_W{1'b0}};
            r_wcnt      <= {WC_W{1'b0}};
            r_page_o    <= {PAGE_W{1'b0}};
            r_in_o      <= {IN_W{1'b0}};
            r_gate_o    <= 1'b0;
            r_busy      <= 1'b0;
            r_sig_valid <= 1'b0;
            r_sig_page  <= {PAGE_W{1'b0}};
            r_signature <= {SIG_W{1'b0}};
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_page      <= w_page;
            r_vec       <= w_vec;
            r_acc       <= w_acc;
            r_wcnt      <= w_wcnt;
            r_page_o    <= w_page_o;
            r_in_o      <= w_in_o;
            r_gate_o    <= w_gate_o;
            r_busy      <= w_busy;
            r_sig_valid <= w_sig_valid;
            r_sig_page  <= w_sig_page;
            r_signature <= w_signature;
            r_done_pend <= w_done_pend;
            r_done      <= w_done;
        end
    end

endmodule

// File: tb/tb_cell_sweep_seq.sv
// Bench for cell_sweep_seq. One instance is built in a small sweep configuration and is
// checked against a cycle-offset model on every cycle. A second instance at default widths
// is used for the manual-forwarding case.
module tb_cell_sweep_seq;

    localparam int V  = 3;        // cycles per vector: SETTLE + 2
    localparam int N  = 4;        // vectors per page
    localparam int NP = 2;        // pages
    localparam int P  = V * N;    // cycles per page
    localparam int T  = P * NP;   // cycles per sweep

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, manual, man_gate;
    logic [4:0]  man_page;
    logic [1:0]  man_in;
    logic        stub_mode;
    logic [7:0]  cell_out;
    logic [4:0]  page_o, sig_page;
    logic [1:0]  in_o;
    logic        gate_o, busy, sig_valid, done;
    logic [15:0] signature;

    logic        dm_start, dm_abort, dm_manual, dm_man_gate;
    logic [4:0]  dm_man_page, dm_page_o, dm_sig_page;
    logic [5:0]  dm_man_in, dm_in_o;
    logic [7:0]  dm_cell;
    logic        dm_gate_o, dm_busy, dm_sig_valid, dm_done;
    logic [15:0] dm_signature;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, expressed as an offset into the sweep rather than as FSM states.
    bit          m_active;
    int          m_k;
    logic [4:0]  m_page_o, m_sig_page;
    logic [1:0]  m_in_o;
    logic        m_gate, m_busy, m_sv, m_done, m_done_pend;
    logic [15:0] m_sig;

    always #5 clk = ~clk;

    // Cell stub: either echoes the applied vector or drives a constant all-ones byte.
    assign cell_out = stub_mode ? 8'hFF : {6'b000000, in_o};

    cell_sweep_seq #(
        .PAGE_W(5), .IN_W(2), .OUT_W(8), .SIG_W(16), .NUM_PAGES(2), .SETTLE(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_manual(manual),
        .man_page(man_page), .man_in(man_in), .man_gate(man_gate), .cell_out(cell_out),
        .page_o(page_o), .in_o(in_o), .gate_o(gate_o), .busy(busy), .sig_valid(sig_valid),
        .sig_page(sig_page), .signature(signature), .done(done)
    );

    cell_sweep_seq u_dm (
        .clk(clk), .rst(rst), .start(dm_start), .abort(dm_abort), .mode_manual(dm_manual),
        .man_page(dm_man_page), .man_in(dm_man_in), .man_gate(dm_man_gate), .cell_out(dm_cell),
        .page_o(dm_page_o), .in_o(dm_in_o), .gate_o(dm_gate_o), .busy(dm_busy),
        .sig_valid(dm_sig_valid), .sig_page(dm_sig_page), .signature(dm_signature), .done(dm_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature of one page: rotate-left-by-one then XOR each of the N samples in order.
    function automatic logic [15:0] page_sig(input logic mode);
        logic [15:0] s;
        s = 16'h0000;
        for (int v = 0; v < N; v++) begin
            s = {s[14:0], s[15]} ^ (mode ? 16'h00FF : 16'(v));
        end
        return s;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_k = 0;
        m_page_o = 5'd0; m_in_o = 2'd0; m_gate = 1'b0; m_busy = 1'b0;
        m_sv = 1'b0; m_sig = 16'h0000; m_sig_page = 5'd0; m_done = 1'b0; m_done_pend = 1'b0;
    endtask

    // Advance the model across one rising edge, using the inputs present before that edge.
    task automatic model_edge();
        int j;
        m_sv        = 1'b0;
        m_done      = m_done_pend;
        m_done_pend = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0; m_busy = 1'b0;
                m_page_o = 5'd0; m_in_o = 2'd0; m_gate = 1'b0;
            end else begin
                m_k++;
                if (m_k < T) begin
                    j        = (m_k - 1) / V;
                    m_page_o = 5'(j / N);
                    m_in_o   = 2'(j % N);
                    m_gate   = 1'b1;
                    if (m_k % P == 0) begin
                        m_sv       = 1'b1;
                        m_sig      = page_sig(stub_mode);
                        m_sig_page = 5'(m_k / P - 1);
                    end
                end else begin
                    m_sv        = 1'b1;
                    m_sig       = page_sig(stub_mode);
                    m_sig_page  = 5'(NP - 1);
                    m_gate      = 1'b0;
                    m_busy      = 1'b0;
                    m_active    = 1'b0;
                    m_done_pend = 1'b1;
                end
            end
        end else begin
            if (manual) begin
                m_page_o = man_page; m_in_o = man_in; m_gate = man_gate;
            end else if (start && !abort) begin
                m_active = 1'b1; m_k = 0; m_busy = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("busy",      32'(busy),      32'(m_busy));
        chk("page_o",    32'(page_o),    32'(m_page_o));
        chk("in_o",      32'(in_o),      32'(m_in_o));
        chk("gate_o",    32'(gate_o),    32'(m_gate));
        chk("sig_valid", 32'(sig_valid), 32'(m_sv));
        chk("sig_page",  32'(sig_page),  32'(m_sig_page));
        chk("signature", 32'(signature), 32'(m_sig));
        chk("done",      32'(done),      32'(m_done));
    endtask

    // One clock: model steps at the rising edge, outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Full sweep with literal checks on pulse timing and per-page signatures.
    task automatic run_sweep(input logic mode, input bit poke, input logic [15:0] lit_sig);
        int          sv_n[2];
        logic [15:0] sv_sig[2];
        int          sv_cnt;
        int          done_n;
        sv_n[0] = 0; sv_n[1] = 0; sv_sig[0] = 16'hxxxx; sv_sig[1] = 16'hxxxx;
        sv_cnt = 0; done_n = 0;
        stub_mode = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 2; n <= T + 4; n++) begin
            if (poke && n == 6) begin start = 1'b1; manual = 1'b1; end
            if (poke && n == 7) begin start = 1'b0; manual = 1'b0; end
            tick();
            if (sig_valid === 1'b1 && sv_cnt < 2) begin
                sv_n[sv_cnt] = n; sv_sig[sv_cnt] = signature; sv_cnt++;
            end
            if (done === 1'b1) done_n = n;
        end
        chk("sv_count",        32'(sv_cnt),    32'd2);
        chk("first_sv_cycle",  32'(sv_n[0]),   32'd13);
        chk("second_sv_cycle", 32'(sv_n[1]),   32'd25);
        chk("done_cycle",      32'(done_n),    32'd26);
        chk("page0_sig",       32'(sv_sig[0]), 32'(lit_sig));
        chk("page1_sig",       32'(sv_sig[1]), 32'(lit_sig));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; manual = 1'b0;
        man_page = 5'd0; man_in = 2'd0; man_gate = 1'b0; stub_mode = 1'b0;
        dm_start = 1'b0; dm_abort = 1'b0; dm_manual = 1'b0;
        dm_man_page = 5'd0; dm_man_in = 6'd0; dm_man_gate = 1'b0; dm_cell = 8'h00;
        model_reset();

        // Reset state
        @(negedge clk);
        compare_all();
        chk("dm_reset_page", 32'(dm_page_o), 32'd0);
        chk("dm_reset_in",   32'(dm_in_o),   32'd0);
        chk("dm_reset_busy", 32'(dm_busy),   32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();

        // T1: echo stub
        run_sweep(1'b0, 1'b0, 16'h0003);
        tick(); tick();

        // T2: constant all-ones stub
        run_sweep(1'b1, 1'b0, 16'h0505);
        tick();

        // T3: abort partway through the first page
        stub_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", 32'(busy),   32'd0);
        chk("abort_page", 32'(page_o), 32'd0);
        chk("abort_in",   32'(in_o),   32'd0);
        chk("abort_gate", 32'(gate_o), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        run_sweep(1'b0, 1'b0, 16'h0003);
        tick();

        // T4: manual forwarding on both instances; start is ignored in manual mode
        dm_manual = 1'b1; dm_man_page = 5'd17; dm_man_in = 6'h2A; dm_man_gate = 1'b1; dm_start = 1'b1;
        manual = 1'b1; man_page = 5'd1; man_in = 2'd2; man_gate = 1'b1; start = 1'b1;
        tick();
        chk("man_dm_page", 32'(dm_page_o), 32'd17);
        chk("man_dm_in",   32'(dm_in_o),   32'h2A);
        chk("man_dm_gate", 32'(dm_gate_o), 32'd1);
        chk("man_dm_busy", 32'(dm_busy),   32'd0);
        chk("man_page",    32'(page_o),    32'd1);
        chk("man_in",      32'(in_o),      32'd2);
        dm_start = 1'b0; dm_manual = 1'b0; start = 1'b0; manual = 1'b0;
        tick(); tick();

        // T5: start and manual poked mid-sweep, then start+abort together in IDLE
        run_sweep(1'b0, 1'b1, 16'h0003);
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        tick(); tick();

        // T6: asynchronous reset while waiting
        start = 1'b1; tick(); start = 1'b0;
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_page",      32'(page_o),    32'd0);
        chk("rst_in",        32'(in_o),      32'd0);
        chk("rst_gate",      32'(gate_o),    32'd0);
        chk("rst_signature", 32'(signature), 32'd0);
        compare_all();
        tick();
        rst = 1'b0;
        tick();
        run_sweep(1'b0, 1'b0, 16'h0003);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
